// File: rtl/gpio_bank_pkg.sv
// Shared register offsets and helper for the HPS GPIO bank.
// The counter-width helper sizes the per-bit debounce counters used under GPIO_DEBOUNCE_EN.
package gpio_bank_pkg;

    localparam logic [2:0] ADDR_DATA_IN    = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT   = 3'd1;
    localparam logic [2:0] ADDR_DIR        = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK   = 3'd3;
    localparam logic [2:0] ADDR_EDGE_CAP   = 3'd4;
    localparam logic [2:0] ADDR_EDGE_RISE  = 3'd5;
    localparam logic [2:0] ADDR_EDGE_FALL  = 3'd6;
    localparam logic [2:0] ADDR_OUT_TOGGLE = 3'd7;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-bit input filter: with GPIO_DEBOUNCE_EN the output follows the input only after
// DEBOUNCE_CYCLES consecutive differing cycles; without it the block is a pass-through.
module gpio_debounce
    import gpio_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

`ifdef GPIO_DEBOUNCE_EN
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          filt_r;

    // Count consecutive cycles where raw disagrees with the filtered value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            filt_r <= 1'b0;
        end else if (raw == filt_r) begin
            cnt_r  <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            filt_r <= raw;
        end else begin
            cnt_r  <= cnt_r + 1'b1;
        end
    end

    assign filt = filt_r;
`else
    logic unused_ok_s;

    assign unused_ok_s = ^{clk, rst_n, DEBOUNCE_CYCLES[0]};
    assign filt        = raw;
`endif

endmodule

// File: rtl/hps_gpio_bank.sv
// Avalon-MM GPIO bank with synchronised inputs, edge capture and a masked level interrupt.
// Define GPIO_DEBOUNCE_EN to insert a per-bit debounce filter after the synchroniser.
module hps_gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_r, sync2_r, filt_s, filt_prev_r;
    logic [WIDTH-1:0] data_out_r, dir_r, irq_mask_r;
    logic [WIDTH-1:0] edge_cap_r, edge_rise_r, edge_fall_r;
    logic [WIDTH-1:0] wdata_s, edge_set_s, cap_clr_s;
    logic [31:0]      rd_mux_s, readdata_r;
    logic             irq_r;

    assign wdata_s = avs_writedata[WIDTH-1:0];

    // Two-flop synchroniser for the asynchronous pad inputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= gpio_in;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .raw   (sync2_r[i]),
            .filt  (filt_s[i])
        );
    end

    assign edge_set_s = (filt_s & ~filt_prev_r & edge_rise_r)
                      | (~filt_s & filt_prev_r & edge_fall_r);

    // W1C strobe for the capture register
    always_comb begin
        cap_clr_s = '0;
        if (avs_write && (avs_address == ADDR_EDGE_CAP)) begin
            cap_clr_s = wdata_s;
        end else begin
            cap_clr_s = '0;
        end
    end

    // Control registers, edge capture and interrupt; a new edge beats a same-cycle clear
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            filt_prev_r <= '0;
            data_out_r  <= '0;
            dir_r       <= '0;
            irq_mask_r  <= '0;
            edge_cap_r  <= '0;
            edge_rise_r <= '0;
            edge_fall_r <= '0;
            irq_r       <= 1'b0;
        end else begin
            filt_prev_r <= filt_s;
            edge_cap_r  <= (edge_cap_r & ~cap_clr_s) | edge_set_s;
            irq_r       <= |(edge_cap_r & irq_mask_r);
            if (avs_write) begin
                case (avs_address)
                    ADDR_DATA_OUT:   data_out_r  <= wdata_s;
                    ADDR_DIR:        dir_r       <= wdata_s;
                    ADDR_IRQ_MASK:   irq_mask_r  <= wdata_s;
                    ADDR_EDGE_RISE:  edge_rise_r <= wdata_s;
                    ADDR_EDGE_FALL:  edge_fall_r <= wdata_s;
                    ADDR_OUT_TOGGLE: data_out_r  <= data_out_r ^ wdata_s;
                    default:         ;
                endcase
            end
        end
    end

    // Read mux; unimplemented upper bits zero-extend
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (avs_address)
            ADDR_DATA_IN:   rd_mux_s = 32'(filt_s);
            ADDR_DATA_OUT:  rd_mux_s = 32'(data_out_r);
            ADDR_DIR:       rd_mux_s = 32'(dir_r);
            ADDR_IRQ_MASK:  rd_mux_s = 32'(irq_mask_r);
            ADDR_EDGE_CAP:  rd_mux_s = 32'(edge_cap_r);
            ADDR_EDGE_RISE: rd_mux_s = 32'(edge_rise_r);
            ADDR_EDGE_FALL: rd_mux_s = 32'(edge_fall_r);
            default:        rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Read data register, held between reads
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata_r <= 32'h0000_0000;
        end else if (avs_read) begin
            readdata_r <= rd_mux_s;
        end
    end

    assign avs_readdata = readdata_r;
    assign gpio_out     = data_out_r;
    assign gpio_oe      = dir_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_hps_gpio_bank.sv
// Directed self-checking bench for hps_gpio_bank (default build or GPIO_DEBOUNCE_EN).
module tb_hps_gpio_bank;

`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata, avs_readdata8;
    logic [31:0] gpio_in, gpio_out, gpio_oe;
    logic [7:0]  gpio_out8, gpio_oe8;
    logic        irq, irq8;
    logic [31:0] rdata;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    hps_gpio_bank dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    hps_gpio_bank #(.WIDTH(8)) dut8 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata8), .gpio_in(gpio_in[7:0]), .gpio_out(gpio_out8),
        .gpio_oe(gpio_oe8), .irq(irq8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    initial begin
        rst_n = 1'b0; avs_address = 3'd0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = 32'h0; gpio_in = 32'h0;
        repeat (3) tick();
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_gpio_oe", gpio_oe, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), rdata);
            check($sformatf("rd_reset_a%0d", a), rdata, 32'h0);
        end
        check("post_rst_oe", gpio_oe, 32'h0);
        check("post_rst_irq", {31'h0, irq}, 32'h0);

        // Output data, direction and toggle
        wr(3'd1, 32'hA5A5_A5A5);
        check("data_out_same_edge", gpio_out, 32'hA5A5_A5A5);
        wr(3'd2, 32'hFFFF_0000);
        wr(3'd7, 32'h0000_000F);
        check("toggle_gpio_out", gpio_out, 32'hA5A5_A5AA);
        check("dir_gpio_oe", gpio_oe, 32'hFFFF_0000);
        rd(3'd1, rdata);
        check("rd_data_out", rdata, 32'hA5A5_A5AA);
        check("w8_rd_data_out", avs_readdata8, 32'h0000_00AA);
        rd(3'd2, rdata);
        check("w8_rd_dir", avs_readdata8, 32'h0000_0000);
        rd(3'd7, rdata);
        check("rd_toggle_zero", rdata, 32'h0);

        // Simultaneous read and write returns pre-write data
        avs_address = 3'd1; avs_writedata = 32'h1234_5678;
        avs_read = 1'b1; avs_write = 1'b1;
        tick();
        avs_read = 1'b0; avs_write = 1'b0;
        check("rw_collide_old", avs_readdata, 32'hA5A5_A5AA);
        rd(3'd1, rdata);
        check("rw_collide_new", rdata, 32'h1234_5678);

        // Rising edge capture and interrupt
        wr(3'd5, 32'h1);
        wr(3'd3, 32'h1);
        gpio_in[0] = 1'b1;
        repeat (LAT + 1) tick();
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        tick();
        check("irq_set", {31'h0, irq}, 32'h1);
        rd(3'd4, rdata);
        check("cap_rise", rdata, 32'h1);
        gpio_in[0] = 1'b0;
        repeat (LAT + 2) tick();
        rd(3'd4, rdata);
        check("cap_no_fall_en", rdata, 32'h1);
        wr(3'd4, 32'h1);
        check("irq_hold_clr", {31'h0, irq}, 32'h1);
        tick();
        check("irq_clr", {31'h0, irq}, 32'h0);
        rd(3'd4, rdata);
        check("cap_cleared", rdata, 32'h0);

        // W1C in the same cycle as a new rising edge
        gpio_in[0] = 1'b1;
        repeat (LAT + 2) tick();
        check("irq_rise2", {31'h0, irq}, 32'h1);
        gpio_in[0] = 1'b0;
        repeat (LAT + 2) tick();
        gpio_in[0] = 1'b1;
        repeat (LAT) tick();
        wr(3'd4, 32'h1);
        check("collide_irq_a", {31'h0, irq}, 32'h1);
        tick();
        check("collide_irq_b", {31'h0, irq}, 32'h1);
        rd(3'd4, rdata);
        check("collide_cap", rdata, 32'h1);

        // Falling edge capture, then masking drops irq
        wr(3'd4, 32'h1);
        wr(3'd5, 32'h0);
        wr(3'd6, 32'h1);
        gpio_in[0] = 1'b0;
        repeat (LAT + 2) tick();
        rd(3'd4, rdata);
        check("cap_fall", rdata, 32'h1);
        check("irq_fall", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h0);
        check("mask_irq_hold", {31'h0, irq}, 32'h1);
        tick();
        check("mask_irq_drop", {31'h0, irq}, 32'h0);

        // Filtered input readback
        wr(3'd4, 32'hFFFF_FFFF);
        wr(3'd6, 32'h0);
        gpio_in = 32'h5A5A_0F60;
        repeat (LAT + 2) tick();
        rd(3'd0, rdata);
        check("data_in", rdata, 32'h5A5A_0F60);
        check("w8_data_in", avs_readdata8, 32'h0000_0060);

        // Filter latency on bit 3; a short pulse is rejected when debounced
        wr(3'd5, 32'h8);
`ifdef GPIO_DEBOUNCE_EN
        gpio_in[3] = 1'b1;
        repeat (10) tick();
        gpio_in[3] = 1'b0;
        repeat (6) tick();
`endif
        gpio_in[3] = 1'b1;
        repeat (LAT - 1) tick();
        rd(3'd0, rdata);
        check("bit3_before", rdata, 32'h5A5A_0F60);
        rd(3'd0, rdata);
        check("bit3_after", rdata, 32'h5A5A_0F68);
        rd(3'd4, rdata);
        check("bit3_single_cap", rdata, 32'h8);

        // Reset mid-filter discards pending state
        wr(3'd4, 32'hFFFF_FFFF);
        gpio_in = 32'h0;
        repeat (LAT + 2) tick();
        gpio_in = 32'hFFFF_FFFF;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_out", gpio_out, 32'h0);
        check("mid_rst_rdata", avs_readdata, 32'h0);
        tick();
        rst_n = 1'b1;
        wr(3'd5, 32'hFFFF_FFFF);
        if (LAT > 2) repeat (LAT - 2) tick();
        rd(3'd4, rdata);
        check("rel_no_early_cap", rdata, 32'h0);
        repeat (3) tick();
        rd(3'd4, rdata);
        check("rel_cap", rdata, 32'hFFFF_FFFF);
        check("rel_irq_masked", {31'h0, irq}, 32'h0);
        wr(3'd4, 32'hFFFF_FFFF);
        repeat (LAT + 4) tick();
        rd(3'd4, rdata);
        check("rel_single_rise", rdata, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hps_gpio_bank.md
HPS_GPIO_BANK -- requirements
Module: hps_gpio_bank

Interface
REQ-001 Parameter WIDTH, default 32: number of GPIO channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of stable cycles required before a filtered input updates; minimum 2.
REQ-003 clk_clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset_reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 avs_address  input  3  Avalon-MM word address.
REQ-006 avs_read  input  1  read strobe.
REQ-007 avs_write  input  1  write strobe.
REQ-008 avs_writedata  input  32  write data.
REQ-009 avs_readdata  output  32  read data; fixed read latency of 1 cycle.
REQ-010 gpio_in  input  WIDTH  asynchronous pad inputs.
REQ-011 gpio_out  output  WIDTH  registered pad output values.
REQ-012 gpio_oe  output  WIDTH  registered output enables; 1 = drive.
REQ-013 irq  output  1  registered level interrupt.

Function
REQ-014 Register map: 0 DATA_IN (read-only, filtered inputs); 1 DATA_OUT (read/write); 2 DIR (read/write, drives gpio_oe); 3 IRQ_MASK (read/write); 4 EDGE_CAP (read, write-1-to-clear); 5 EDGE_RISE (read/write); 6 EDGE_FALL (read/write); 7 OUT_TOGGLE (write XORs DATA_OUT, reads 0).
REQ-015 Bits at or above WIDTH read as 0 and ignore writes.
REQ-016 Each gpio_in bit passes through a 2-flop synchroniser before any other use.
REQ-017 avs_readdata updates one cycle after the avs_read cycle and holds its value until the next read.
REQ-018 Writes take effect on the clock edge that samples avs_write; gpio_out and gpio_oe change on that same edge.
REQ-019 Edge detection compares the filtered value with its value one cycle earlier; a rising edge sets EDGE_CAP[i] when EDGE_RISE[i]=1; a falling edge sets it when EDGE_FALL[i]=1.
REQ-020 If an edge set and a W1C clear hit the same bit in the same cycle, the set wins and the bit reads 1.
REQ-021 irq is registered as OR(EDGE_CAP & IRQ_MASK) and asserts one cycle after the capture bit sets.
REQ-022 Clearing the last masked capture bit, or masking it, deasserts irq one cycle later.
REQ-023 avs_read and avs_write asserted together: the write executes, and the read returns pre-write data.

Reset
REQ-024 On reset: all registers, avs_readdata, gpio_out, gpio_oe and irq are 0.
REQ-025 On reset: synchroniser and filter state are 0, and debounce counters are 0.
REQ-026 Reset asserted mid-debounce or mid-capture discards pending state, so no edge is reported at reset release.

Configuration
REQ-027 With GPIO_DEBOUNCE_EN defined, each synchronised bit has a counter that resets to 0 whenever the raw value equals the filtered value.
REQ-028 With GPIO_DEBOUNCE_EN defined, the filtered bit takes the raw value when the counter reaches DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-029 With GPIO_DEBOUNCE_EN undefined, the filtered value equals the synchroniser output, no counters exist, and the DEBOUNCE_CYCLES parameter is ignored.

Structure
REQ-030 Package gpio_bank_pkg holds the register offset constants (ADDR_DATA_IN ... ADDR_OUT_TOGGLE) and the counter-width function $clog2(DEBOUNCE_CYCLES).
REQ-031 A single sub-module, gpio_debounce, is instantiated once per bit under generate; when GPIO_DEBOUNCE_EN is undefined it is a pass-through.

Verification
REQ-032 Reset, then read all 8 addresses -> every read returns 0x00000000, and gpio_oe=0, irq=0.
REQ-033 Write DATA_OUT=0xA5A5A5A5, DIR=0xFFFF0000, then OUT_TOGGLE=0x0000000F -> gpio_out=0xA5A5A5AA, gpio_oe=0xFFFF0000, and a DATA_OUT read returns 0xA5A5A5AA.
REQ-034 Debounce on: drive gpio_in[3] high for 10 cycles, low, then high for 20 cycles -> DATA_IN[3] rises only after 2+16 cycles of the second pulse, and a single edge is captured.
REQ-035 Set EDGE_RISE=0x1, IRQ_MASK=0x1, pulse bit0 -> EDGE_CAP=0x1 and irq=1; write EDGE_CAP=0x1 -> irq=0 one cycle later.
REQ-036 Issue a W1C to bit0 in the same cycle as a new rising edge -> EDGE_CAP[0] remains 1 and irq remains 1.
REQ-037 Assert reset_reset_n low mid-debounce, release with gpio_in=0xFFFFFFFF -> no capture occurs before the debounce completes, and exactly one rise is captured if EDGE_RISE is set after release.
